light_sequencer: RTL and testbench
==================================

Name: light_sequencer

Overview:
Three-state traffic-light sequencer (RED -> GREEN -> YELLOW -> RED) that consumes the slow tick produced by the divider/counter stage. Each state lasts a programmable number of ticks. A pedestrian-request handshake shortens GREEN. Outputs drive the lamp drivers directly.

Parameters:
CNT_W, 4, width of dwell counter; every *_TICKS must be <= 2**CNT_W.
RED_TICKS, 6, ticks spent in RED (>=1).
GREEN_TICKS, 8, ticks spent in GREEN (>=2).
YELLOW_TICKS, 2, ticks spent in YELLOW (>=1).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
tick  input  1  one-cycle enable pulse from the upstream slow-clock stage; all dwell counting happens only on tick=1.
req  input  1  pedestrian request, level, synchronous to clk.
lights  output  3  one-hot {red, yellow, green}.
state  output  2  current state code: 0 RED, 1 GREEN, 2 YELLOW, 3 FLASH (FLASH only with the option).
remain  output  CNT_W  ticks left in the current state, minus 1.
req_ack  output  1  one-cycle pulse granting a pending request.

Behaviour:
- Reset (reset=0 at clk edge): state=RED, remain=RED_TICKS-1, lights=3'b100, req_ack=0, pending=0. Takes priority over every other input; mid-state reset restarts the full RED period.
- All outputs are registered. lights and state change on the same edge.
- On tick with remain>0: remain decrements. On tick with remain==0: advance to the next state and load remain=NEXT_TICKS-1. Each state therefore lasts exactly *_TICKS ticks.
- No tick: state and remain hold. Cycles without tick never change any output except req_ack clearing.
- pending flag: set on any cycle with req=1 while state is GREEN or YELLOW. Ignored in RED. Clearing happens on the edge that enters RED.
- GREEN shortening: on tick in GREEN with pending=1 and remain>1, remain loads 1 instead of decrementing. GREEN then ends after at most 2 further ticks.
- req_ack: high exactly for the first clk cycle in RED when pending was 1 at the transition edge. Otherwise 0.
- Simultaneous req=1 on the RED-entry edge: clear wins. No pending, no ack for that request.
- remain never wraps. A decrement from 0 cannot occur because the transition takes precedence.

Optional Feature:
LIGHT_SEQ_FLASH_EN.
- Defined: adds input port flash (1 bit). While flash=1, the block enters FLASH (state=3) on the next edge. Lights are {0,blink,0}, where blink starts at 1 and toggles on each tick. remain holds 0, and pending is cleared and blocked. On flash falling, the next edge enters RED with remain=RED_TICKS-1 and req_ack=0. Reset overrides flash.
- Undefined: no flash port. State 3 is unreachable; a decode of code 3 falls back to RED.

Decomposition:
- Package light_pkg: state codes (ST_RED, ST_GREEN, ST_YELLOW, ST_FLASH), lamp bit indices (LAMP_RED=2, LAMP_YEL=1, LAMP_GRN=0), and a next-state function.
- Sub-module dwell_timer: loadable down-counter with tick enable, load value, and zero flag. light_sequencer instantiates one and holds the FSM plus the request logic.

Test Plan:
- Reset held low 3 cycles, then released, no req, tick every 4 clks: RED for 6 ticks, GREEN 8, YELLOW 2, RED again. lights sequence 100 -> 001 -> 010 -> 100. remain counts 5..0, 7..0, 1..0.
- tick held 0 for 50 cycles after reset: state=RED, remain=5 constant, req_ack=0 throughout.
- req pulse 1 clk at GREEN remain=6, then ticks: next tick loads remain=1, YELLOW after 2 ticks, then RED after 2 more. req_ack=1 for exactly the first RED cycle.
- req held high during RED only: no pending, GREEN lasts full 8 ticks, req_ack stays 0.
- reset=0 asserted at YELLOW remain=0 coincident with tick: next state RED, remain=5, req_ack=0 (reset beats transition).
- LIGHT_SEQ_FLASH_EN: flash=1 in GREEN gives state=3 and lights toggling 010/000 per tick. Dropping flash gives RED, remain=5.

Source files
------------

// File: rtl/light_pkg.sv
// Shared state codes, lamp bit positions and sequencing helpers for the traffic-light sequencer.
// The FLASH lamp decode exists only when LIGHT_SEQ_FLASH_EN is defined.
package light_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  localparam int LAMP_RED = 2;
  localparam int LAMP_YEL = 1;
  localparam int LAMP_GRN = 0;

  // Normal cycle order; any unexpected code (including FLASH) resumes at RED.
  function automatic state_t next_state(input state_t st);
    case (st)
      ST_RED:    return ST_GREEN;
      ST_GREEN:  return ST_YELLOW;
      default:   return ST_RED;
    endcase
  endfunction

  // Base lamp pattern for a state; FLASH blink gating is applied by the caller.
  function automatic logic [2:0] lamp_mask(input state_t st);
    logic [2:0] m;
    m = '0;
    case (st)
      ST_GREEN:  m[LAMP_GRN] = 1'b1;
      ST_YELLOW: m[LAMP_YEL] = 1'b1;
`ifdef LIGHT_SEQ_FLASH_EN
      ST_FLASH:  m[LAMP_YEL] = 1'b1;
`endif
      default:   m[LAMP_RED] = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter advanced by the slow tick; parks at zero and exposes a zero flag.
// A load always wins over counting so the owner can restart or shorten a period at any time.
module dwell_timer #(
  parameter int               CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (tick && (count_reg != '0)) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= RST_VAL;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/light_sequencer.sv
// RED -> GREEN -> YELLOW traffic-light sequencer with pedestrian-request shortening of GREEN.
// Define LIGHT_SEQ_FLASH_EN to add the flash input and the blinking-yellow FLASH state.
module light_sequencer
  import light_pkg::*;
#(
  parameter int CNT_W        = 4,
  parameter int RED_TICKS    = 6,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             req,
`ifdef LIGHT_SEQ_FLASH_EN
  input  logic             flash,
`endif
  output logic [2:0]       lights,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] remain,
  output logic             req_ack
);

  localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);

  state_t           state_reg, state_next;
  logic             pending_reg, pending_next;
  logic             ack_reg, ack_next;
  logic [2:0]       lights_reg, lights_next;
  logic [2:0]       base_mask;
  logic             yel_gate;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] remain_cnt;
  logic             remain_zero;
`ifdef LIGHT_SEQ_FLASH_EN
  logic             blink_reg, blink_next;
`endif

  function automatic logic [CNT_W-1:0] load_for(input state_t st);
    case (st)
      ST_GREEN:  return GREEN_LOAD;
      ST_YELLOW: return YELLOW_LOAD;
      default:   return RED_LOAD;
    endcase
  endfunction

  dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RED_LOAD)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .count    (remain_cnt),
    .zero     (remain_zero)
  );

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    ack_next     = 1'b0;
    load         = 1'b0;
    load_val     = remain_cnt;
    yel_gate     = 1'b1;
`ifdef LIGHT_SEQ_FLASH_EN
    blink_next   = blink_reg;
`endif

    if (tick && remain_zero) begin
      state_next = next_state(state_reg);
      load       = 1'b1;
      load_val   = load_for(state_next);
    end else if (tick && (state_reg == ST_GREEN) && pending_reg && (remain_cnt > CNT_W'(1))) begin
      // A waiting pedestrian cuts GREEN down to its last two ticks.
      load     = 1'b1;
      load_val = CNT_W'(1);
    end

    // Entering RED retires the request; a req on that same edge is dropped.
    if ((state_next == ST_RED) && (state_reg != ST_RED)) begin
      pending_next = 1'b0;
      ack_next     = pending_reg;
    end else if (req && ((state_reg == ST_GREEN) || (state_reg == ST_YELLOW))) begin
      pending_next = 1'b1;
    end

`ifdef LIGHT_SEQ_FLASH_EN
    if (flash) begin
      state_next   = ST_FLASH;
      load         = 1'b1;
      load_val     = '0;
      pending_next = 1'b0;
      ack_next     = 1'b0;
      blink_next   = (state_reg != ST_FLASH) ? 1'b1 : (blink_reg ^ tick);
    end else if (state_reg == ST_FLASH) begin
      state_next   = ST_RED;
      load         = 1'b1;
      load_val     = RED_LOAD;
      pending_next = 1'b0;
      ack_next     = 1'b0;
    end
    if (state_next == ST_FLASH) begin
      yel_gate = blink_next;
    end
`endif

    base_mask = lamp_mask(state_next);
  end

  // Lamps are decoded from the next state so they switch on the same edge as state.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
    if (gi == LAMP_YEL) begin : g_yel
      assign lights_next[gi] = base_mask[gi] & yel_gate;
    end else begin : g_other
      assign lights_next[gi] = base_mask[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_RED;
      pending_reg <= 1'b0;
      ack_reg     <= 1'b0;
      lights_reg  <= lamp_mask(ST_RED);
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      ack_reg     <= ack_next;
      lights_reg  <= lights_next;
    end
  end

`ifdef LIGHT_SEQ_FLASH_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_reg <= 1'b1;
    end else begin
      blink_reg <= blink_next;
    end
  end
`endif

  assign lights  = lights_reg;
  assign state   = state_reg;
  assign remain  = remain_cnt;
  assign req_ack = ack_reg;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: tick-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic (flash when LIGHT_SEQ_FLASH_EN).
`timescale 1ns/1ps
module tb_light_sequencer;

  localparam int CNT_W = 4;
  int dur [3] = '{6, 8, 2};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic req = 1'b0;
`ifdef LIGHT_SEQ_FLASH_EN
  logic flash = 1'b0;
`endif
  logic [2:0]       lights;
  logic [1:0]       state;
  logic [CNT_W-1:0] remain;
  logic             req_ack;

  always #5 clk = ~clk;

  light_sequencer #(
    .CNT_W        (CNT_W),
    .RED_TICKS    (6),
    .GREEN_TICKS  (8),
    .YELLOW_TICKS (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .req     (req),
`ifdef LIGHT_SEQ_FLASH_EN
    .flash   (flash),
`endif
    .lights  (lights),
    .state   (state),
    .remain  (remain),
    .req_ack (req_ack)
  );

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;
  int ntick = 0;

  // Reference model in "ticks still to spend in this state" terms.
  int m_st = 0;
  int m_left = 6;
  bit m_pend = 1'b0;
  bit m_ack = 1'b0;
  bit m_blink = 1'b1;

  always @(posedge clk) begin : model
    int old_st;
    bit fl;
    fl = 1'b0;
`ifdef LIGHT_SEQ_FLASH_EN
    fl = flash;
`endif
    old_st = m_st;
    if (!reset) begin
      m_st = 0; m_left = dur[0]; m_pend = 0; m_ack = 0;
    end else if (fl) begin
      m_blink = (old_st == 3) ? (m_blink ^ tick) : 1'b1;
      m_st = 3; m_left = 1; m_pend = 0; m_ack = 0;
    end else if (old_st == 3) begin
      m_st = 0; m_left = dur[0]; m_pend = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (tick) begin
        if (m_left == 1) begin
          m_st = (old_st + 1) % 3;
          m_left = dur[m_st];
        end else if (old_st == 1 && m_pend && m_left > 2) begin
          m_left = 2;
        end else begin
          m_left = m_left - 1;
        end
      end
      if (m_st == 0 && old_st != 0) begin
        m_ack = m_pend;
        m_pend = 0;
      end else if (req && old_st != 0) begin
        m_pend = 1;
      end
    end
  end

  function automatic logic [2:0] exp_lights(input int st, input bit blink);
    case (st)
      0:       return 3'b100;
      1:       return 3'b001;
      2:       return 3'b010;
      default: return {1'b0, blink, 1'b0};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_state",  {6'b0, state},   8'(m_st));
      chk("model_remain", {4'b0, remain},  8'(m_left - 1));
      chk("model_lights", {5'b0, lights},  {5'b0, exp_lights(m_st, m_blink)});
      chk("model_ack",    {7'b0, req_ack}, {7'b0, m_ack});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ntick++;
    $display("[TB] tick %0d: state=%0d remain=%0d lights=%b req_ack=%b",
             ntick, state, remain, lights, req_ack);
  endtask

  task automatic pin(input string nm, input logic [1:0] st, input logic [CNT_W-1:0] rm,
                     input logic [2:0] lt, input logic ak);
    chk({nm, "_state"},  {6'b0, state},   {6'b0, st});
    chk({nm, "_remain"}, {4'b0, remain},  {4'b0, rm});
    chk({nm, "_lights"}, {5'b0, lights},  {5'b0, lt});
    chk({nm, "_ack"},    {7'b0, req_ack}, {7'b0, ak});
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0;
    cyc(3);
    reset = 1'b1;
    check_en = 1'b1;
    pin("reset", 2'd0, 4'd5, 3'b100, 1'b0);

    cyc(50);
    pin("idle50", 2'd0, 4'd5, 3'b100, 1'b0);

    // Full cycle with no request, tick every 4 clocks.
    for (int i = 0; i < 16; i++) begin
      pulse_tick();
      if (i == 5)  pin("to_green",  2'd1, 4'd7, 3'b001, 1'b0);
      if (i == 13) pin("to_yellow", 2'd2, 4'd1, 3'b010, 1'b0);
      if (i == 15) pin("to_red",    2'd0, 4'd5, 3'b100, 1'b0);
      cyc(3);
    end

    // Request at GREEN remain=6 shortens GREEN.
    for (int i = 0; i < 7; i++) begin pulse_tick(); cyc(3); end
    pin("green6", 2'd1, 4'd6, 3'b001, 1'b0);
    req = 1'b1; cyc(1); req = 1'b0;
    pulse_tick(); pin("short_load", 2'd1, 4'd1, 3'b001, 1'b0); cyc(3);
    pulse_tick(); cyc(3);
    pulse_tick(); pin("short_yel", 2'd2, 4'd1, 3'b010, 1'b0); cyc(3);
    pulse_tick(); cyc(3);
    pulse_tick(); pin("ack_first", 2'd0, 4'd5, 3'b100, 1'b1);
    cyc(1);       pin("ack_clear", 2'd0, 4'd5, 3'b100, 1'b0);

    // Request held only during RED is ignored.
    req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pulse_tick();
      if (i < 5) cyc(3);
    end
    req = 1'b0;
    pin("red_req_green", 2'd1, 4'd7, 3'b001, 1'b0);
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      if (i == 6) pin("full_green_end", 2'd1, 4'd0, 3'b001, 1'b0);
      if (i == 7) pin("full_green_yel", 2'd2, 4'd1, 3'b010, 1'b0);
      cyc(3);
    end
    pulse_tick(); cyc(3);
    pulse_tick(); pin("no_ack", 2'd0, 4'd5, 3'b100, 1'b0); cyc(3);

    // Reset at YELLOW remain=0 coincident with tick, with a pending request.
    for (int i = 0; i < 6; i++) begin pulse_tick(); cyc(3); end
    req = 1'b1; cyc(1); req = 1'b0;
    for (int i = 0; i < 4; i++) begin pulse_tick(); cyc(3); end
    pin("yel_zero", 2'd2, 4'd0, 3'b010, 1'b0);
    reset = 1'b0; tick = 1'b1;
    @(negedge clk);
    reset = 1'b1; tick = 1'b0;
    pin("reset_wins", 2'd0, 4'd5, 3'b100, 1'b0);
    cyc(1);
    pin("reset_noack", 2'd0, 4'd5, 3'b100, 1'b0);

`ifdef LIGHT_SEQ_FLASH_EN
    for (int i = 0; i < 6; i++) begin pulse_tick(); cyc(3); end
    flash = 1'b1; cyc(1);
    pin("flash_on", 2'd3, 4'd0, 3'b010, 1'b0);
    pulse_tick(); pin("flash_blink0", 2'd3, 4'd0, 3'b000, 1'b0);
    pulse_tick(); pin("flash_blink1", 2'd3, 4'd0, 3'b010, 1'b0);
    flash = 1'b0; cyc(1);
    pin("flash_off", 2'd0, 4'd5, 3'b100, 1'b0);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) req = ~req;
      reset = ($urandom_range(0, 299) != 0);
`ifdef LIGHT_SEQ_FLASH_EN
      if ($urandom_range(0, 399) == 0) flash = ~flash;
`endif
      @(negedge clk);
    end
    tick = 1'b0; req = 1'b0; reset = 1'b1;
`ifdef LIGHT_SEQ_FLASH_EN
    flash = 1'b0;
`endif
    cyc(2);
    $display("[TB] random phase: 4000 cycles");

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
